// File: rtl/alu_multibyte_seq.sv
// -----------------------------------------------------------------------------
// alu_multibyte_seq
//
// Runs an external 8-bit ALU over N-byte operands that live in a single-port
// data memory. It supports multi-byte ADD, SUB, SHL, SHR, XOR and AND.
//
// For each byte the sequencer reads the A byte, then the B byte (shifts skip
// the B read). It then drives the ALU and writes the result byte back in the
// same cycle. The ALU carry/shift-out is registered between bytes so that the
// carry ripples through the whole operand.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   start             request, sampled only while idle
//   op_i              0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 XOR, 5 AND (6,7 reserved)
//   a_base_i          address of byte 0 (LSB) of operand A
//   b_base_i          address of byte 0 of operand B (unused for shifts)
//   d_base_i          address of byte 0 of the destination
//   len_i             operand length in bytes
//   shift_in_i        bit shifted into the vacated end for SHL/SHR
//   busy / done       busy in every non-idle state; done is a one-cycle pulse
//   carry_o, zero_o   final carry and all-zero flag, held until next start
//   mem_*             single-port data memory (combinational read)
//   alu_*             external 8-bit ALU (combinational)
// -----------------------------------------------------------------------------
module alu_multibyte_seq #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op_i,
    input  logic [ADDR_W-1:0] a_base_i,
    input  logic [ADDR_W-1:0] b_base_i,
    input  logic [ADDR_W-1:0] d_base_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              shift_in_i,
    output logic              busy,
    output logic              done,
    output logic              carry_o,
    output logic              zero_o,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic [3:0]        alu_cmd,
    output logic [7:0]        alu_inA,
    output logic [7:0]        alu_inB,
    output logic              alu_sc_i,
    input  logic [7:0]        alu_rslt,
    input  logic              alu_sc_o
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SHL = 3'd2;
    localparam logic [2:0] OP_SHR = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SHL = 4'b0001;
    localparam logic [3:0] CMD_SHR = 4'b0010;
    localparam logic [3:0] CMD_XOR = 4'b0011;
    localparam logic [3:0] CMD_AND = 4'b0100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_EXEC,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [ADDR_W-1:0]  a_base_q, a_base_d;
    logic [ADDR_W-1:0]  b_base_q, b_base_d;
    logic [ADDR_W-1:0]  d_base_q, d_base_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               shin_q, shin_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;      // bytes already processed
    logic [7:0]         a_byte_q, a_byte_d;
    logic [7:0]         b_byte_q, b_byte_d;
    logic               carry_q, carry_d;  // running carry, final value is carry_o
    logic               zero_q, zero_d;

    // Per-byte decode of the latched operation
    logic               is_shift;
    logic               is_logic;
    logic               first_byte;
    logic               last_byte;
    logic [LEN_W-1:0]   idx;
    logic [ADDR_W-1:0]  idx_ext;
    logic               op_valid_i;

    assign is_shift   = (op_q == OP_SHL) || (op_q == OP_SHR);
    assign is_logic   = (op_q == OP_XOR) || (op_q == OP_AND);
    assign first_byte = (cnt_q == '0);
    assign last_byte  = (cnt_q == (len_q - LEN_W'(1)));
    // SHR must walk from the MSB down so that the shift-out of a higher byte
    // becomes the shift-in of the next lower byte.
    assign idx        = (op_q == OP_SHR) ? (len_q - LEN_W'(1) - cnt_q) : cnt_q;
    assign idx_ext    = ADDR_W'(idx);
    assign op_valid_i = (op_i <= OP_AND);

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign carry_o = carry_q;
    assign zero_o  = zero_q;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            d_base_q <= '0;
            len_q    <= '0;
            shin_q   <= 1'b0;
            cnt_q    <= '0;
            a_byte_q <= '0;
            b_byte_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            d_base_q <= d_base_d;
            len_q    <= len_d;
            shin_q   <= shin_d;
            cnt_q    <= cnt_d;
            a_byte_q <= a_byte_d;
            b_byte_q <= b_byte_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_base_d  = a_base_q;
        b_base_d  = b_base_q;
        d_base_d  = d_base_q;
        len_d     = len_q;
        shin_d    = shin_q;
        cnt_d     = cnt_q;
        a_byte_d  = a_byte_q;
        b_byte_d  = b_byte_q;
        carry_d   = carry_q;
        zero_d    = zero_q;

        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        alu_cmd   = CMD_ADD;
        alu_inA   = '0;
        alu_inB   = '0;
        alu_sc_i  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = op_i;
                    a_base_d = a_base_i;
                    b_base_d = b_base_i;
                    d_base_d = d_base_i;
                    len_d    = len_i;
                    shin_d   = shift_in_i;
                    cnt_d    = '0;
                    carry_d  = 1'b0;
                    zero_d   = 1'b1;
                    // Empty or reserved requests finish at once with no writes
                    // and with the flags left at their cleared values.
                    if ((len_i != '0) && op_valid_i)
                        state_d = S_RD_A;
                    else
                        state_d = S_DONE;
                end
            end

            S_RD_A: begin
                mem_addr = a_base_q + idx_ext;
                a_byte_d = mem_rdata;
                state_d  = is_shift ? S_EXEC : S_RD_B;
            end

            S_RD_B: begin
                mem_addr = b_base_q + idx_ext;
                b_byte_d = mem_rdata;
                state_d  = S_EXEC;
            end

            S_EXEC: begin
                alu_inA = a_byte_q;
                case (op_q)
                    OP_ADD: begin alu_cmd = CMD_ADD; alu_inB = b_byte_q;  end
                    OP_SUB: begin alu_cmd = CMD_ADD; alu_inB = ~b_byte_q; end
                    OP_SHL: begin alu_cmd = CMD_SHL; alu_inB = '0;        end
                    OP_SHR: begin alu_cmd = CMD_SHR; alu_inB = '0;        end
                    OP_XOR: begin alu_cmd = CMD_XOR; alu_inB = b_byte_q;  end
                    default: begin alu_cmd = CMD_AND; alu_inB = b_byte_q; end
                endcase

                // Seed the chain on byte 0. SUB is A + ~B + 1.
                if (first_byte) begin
                    case (op_q)
                        OP_SUB:         alu_sc_i = 1'b1;
                        OP_SHL, OP_SHR: alu_sc_i = shin_q;
                        default:        alu_sc_i = 1'b0;
                    endcase
                end else begin
                    alu_sc_i = is_logic ? 1'b0 : carry_q;
                end

                mem_addr  = d_base_q + idx_ext;
                mem_we    = 1'b1;
                mem_wdata = alu_rslt;
                carry_d   = is_logic ? 1'b0 : alu_sc_o;
                zero_d    = zero_q & (alu_rslt == 8'h00);

                if (last_byte) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + LEN_W'(1);
                    state_d = S_RD_A;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
